// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - one FC layer sequencer: load, broadcast, collect, drain.
// Optional WAIT watchdog enabled by defining LAYER_SCHED_TIMEOUT_EN.
module layer_scheduler #(
  parameter int NUM_INPUT  = 784,
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            neuron_in,
  output logic                             neuron_in_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURON-1:0]            neuron_out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             error
);

  localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int NW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [IW-1:0] LAST_IN = IW'(NUM_INPUT - 1);
  localparam logic [NW-1:0] LAST_N  = NW'(NUM_NEURON - 1);

  typedef enum logic [1:0] {S_LOAD, S_BROADCAST, S_WAIT, S_DRAIN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   ibuf [NUM_INPUT];
  logic [DATA_WIDTH-1:0]   obuf [NUM_NEURON];
  logic [IW-1:0]           wptr;
  logic [IW-1:0]           bptr;
  logic [NW-1:0]           rptr;
  logic [NUM_NEURON-1:0]   got;
  logic                    all_got;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   first_in;
  logic [DATA_WIDTH-1:0]   first_out;

  assign all_got = &(got | neuron_out_valid);
  // Bypass covers the single-word case where ibuf[0] is written on the same edge.
  assign first_in  = (wptr == '0) ? in_data : ibuf[0];
  assign first_out = neuron_out_valid[0] ? neuron_out[0 +: DATA_WIDTH] : obuf[0];

`ifdef LAYER_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_T = CW'(TIMEOUT - 1);
  logic [CW-1:0] tcnt;
  assign timeout_hit = (tcnt == LAST_T);
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_LOAD;
      in_ready        <= 1'b0;
      neuron_in       <= '0;
      neuron_in_valid <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      wptr            <= '0;
      bptr            <= '0;
      rptr            <= '0;
      got             <= '0;
`ifdef LAYER_SCHED_TIMEOUT_EN
      error           <= 1'b0;
      tcnt            <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            ibuf[wptr] <= in_data;
            if (wptr == LAST_IN) begin
              wptr            <= '0;
              bptr            <= '0;
              in_ready        <= 1'b0;
              busy            <= 1'b1;
              neuron_in_valid <= 1'b1;
              neuron_in       <= first_in;
              state           <= S_BROADCAST;
            end else begin
              wptr <= wptr + IW'(1);
            end
          end
        end
        S_BROADCAST: begin
          if (bptr == LAST_IN) begin
            neuron_in_valid <= 1'b0;
            got             <= '0;
            // Stale results must not leak out if a neuron never reports.
            for (int k = 0; k < NUM_NEURON; k++) obuf[k] <= '0;
`ifdef LAYER_SCHED_TIMEOUT_EN
            tcnt            <= '0;
`endif
            state           <= S_WAIT;
          end else begin
            bptr      <= bptr + IW'(1);
            neuron_in <= ibuf[bptr + IW'(1)];
          end
        end
        S_WAIT: begin
          for (int k = 0; k < NUM_NEURON; k++)
            if (neuron_out_valid[k]) obuf[k] <= neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
          if (all_got || timeout_hit) begin
            got       <= '0;
            rptr      <= '0;
            out_valid <= 1'b1;
            out_data  <= first_out;
            out_last  <= (LAST_N == '0);
            state     <= S_DRAIN;
`ifdef LAYER_SCHED_TIMEOUT_EN
            if (!all_got) error <= 1'b1;
`endif
          end else begin
            got <= got | neuron_out_valid;
`ifdef LAYER_SCHED_TIMEOUT_EN
            tcnt <= tcnt + CW'(1);
`endif
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            if (rptr == LAST_N) begin
              rptr      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_LOAD;
            end else begin
              rptr     <= rptr + NW'(1);
              out_data <= obuf[rptr + NW'(1)];
              out_last <= ((rptr + NW'(1)) == LAST_N);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - directed self-checking bench for layer_scheduler.
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] neuron_in;
  logic        neuron_in_valid;
  logic [47:0] neuron_out;
  logic [2:0]  neuron_out_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;

  layer_scheduler #(
    .NUM_INPUT(4), .NUM_NEURON(3), .DATA_WIDTH(16), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
    .neuron_out(neuron_out), .neuron_out_valid(neuron_out_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < 4; i++) begin
      chk("load_in_ready", in_ready, 1'b1);
      in_data  = base + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 16'h0;
  endtask

  task automatic check_bcast(input logic [15:0] base);
    for (int i = 0; i < 4; i++) begin
      chk("bcast_valid", neuron_in_valid, 1'b1);
      chk("bcast_word", neuron_in, base + 16'(i));
      tick();
    end
    chk("bcast_end_valid", neuron_in_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0;
    neuron_out = '0; neuron_out_valid = '0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_nvalid", neuron_in_valid, 1'b0);
    chk("rst_nin", neuron_in, 16'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Basic load and gapless broadcast
    load(16'h0001);
    chk("in_ready_after_load", in_ready, 1'b0);
    chk("busy_bcast", busy, 1'b1);
    check_bcast(16'h0001);

    // Split pulses, then drain with a stall mid-stream
    neuron_out = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    neuron_out_valid = 3'b001;
    tick();
    neuron_out_valid = 3'b000;
    chk("wait_partial", out_valid, 1'b0);
    tick();
    neuron_out_valid = 3'b110;
    tick();
    neuron_out_valid = 3'b000;
    neuron_out = {3{16'hDEAD}};
    chk("drain_v0", out_valid, 1'b1);
    chk("drain_d0", out_data, 16'hAAAA);
    chk("drain_l0", out_last, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("drain_d1", out_data, 16'hBBBB);
    chk("drain_l1", out_last, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 16'hBBBB);
    end
    out_ready = 1'b1;
    tick();
    chk("drain_d2", out_data, 16'hCCCC);
    chk("drain_l2", out_last, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("drain_done_valid", out_valid, 1'b0);
    chk("drain_done_last", out_last, 1'b0);
    chk("drain_done_in_ready", in_ready, 1'b1);
    chk("drain_done_busy", busy, 1'b0);

    // Pulses during broadcast must be ignored
    load(16'h0010);
    neuron_out = {3{16'hEEEE}};
    neuron_out_valid = 3'b111;
    tick();
    neuron_out_valid = 3'b000;
    tick(); tick(); tick();
    chk("ign_nvalid", neuron_in_valid, 1'b0);
    chk("ign_out_valid", out_valid, 1'b0);
    tick(); tick();
    chk("ign_still_wait", out_valid, 1'b0);
    neuron_out = {16'h1113, 16'h1112, 16'h1111};
    neuron_out_valid = 3'b111;
    tick();
    neuron_out_valid = 3'b000;
    chk("ign_v0", out_valid, 1'b1);
    chk("ign_d0", out_data, 16'h1111);
    out_ready = 1'b1;
    tick();
    chk("ign_d1", out_data, 16'h1112);
    tick();
    chk("ign_d2", out_data, 16'h1113);
    chk("ign_l2", out_last, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("ign_done", out_valid, 1'b0);

    // Reset mid-broadcast, then a clean reload
    load(16'h0021);
    chk("mid_w0", neuron_in, 16'h0021);
    tick();
    chk("mid_w1", neuron_in, 16'h0022);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_nvalid", neuron_in_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    load(16'h0031);
    check_bcast(16'h0031);

`ifdef LAYER_SCHED_TIMEOUT_EN
    neuron_out = {16'h7777, 16'h4444, 16'h3333};
    neuron_out_valid = 3'b011;
    tick();
    neuron_out_valid = 3'b000;
    for (int i = 0; i < 6; i++) tick();
    chk("to_before_err", error, 1'b0);
    chk("to_before_valid", out_valid, 1'b0);
    tick();
    chk("to_err", error, 1'b1);
    chk("to_v0", out_valid, 1'b1);
    chk("to_d0", out_data, 16'h3333);
    out_ready = 1'b1;
    tick();
    chk("to_d1", out_data, 16'h4444);
    tick();
    chk("to_d2", out_data, 16'h0000);
    chk("to_l2", out_last, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("to_done", out_valid, 1'b0);
    chk("to_sticky", error, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_rst_clear", error, 1'b0);
`else
    for (int i = 0; i < 12; i++) tick();
    chk("nto_error", error, 1'b0);
    chk("nto_still_wait", out_valid, 1'b0);
    neuron_out = {16'h7777, 16'h4444, 16'h3333};
    neuron_out_valid = 3'b111;
    tick();
    neuron_out_valid = 3'b000;
    chk("nto_d0", out_data, 16'h3333);
    out_ready = 1'b1;
    tick();
    chk("nto_d1", out_data, 16'h4444);
    tick();
    chk("nto_d2", out_data, 16'h7777);
    chk("nto_l2", out_last, 1'b1);
    tick();
    out_ready = 1'b0;
    chk("nto_done", out_valid, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
